// File: rtl/mips_alu.sv
// 32-bit MIPS-style execute-stage ALU with registered result and status flags.
// One clock of latency; zero/negative are derived from the registered result.
module mips_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  aluc,
  output logic [31:0] r,
  output logic        zero,
  output logic        carry,
  output logic        negative,
  output logic        overflow,
  output logic        flag
);

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDU = 6'b100001;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_SUBU = 6'b100011;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_SLLV = 6'b000100;
  localparam logic [5:0] OP_SRLV = 6'b000110;
  localparam logic [5:0] OP_SRAV = 6'b000111;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  logic [31:0] r_reg, r_next;
  logic        carry_reg, carry_next;
  logic        overflow_reg, overflow_next;
  logic        flag_reg, flag_next;

  logic [32:0] sum, diff, sll_ext, srl_ext, sra_ext;
  logic [4:0]  shamt;
  logic        slt, sltu;

  // Shifts are done one bit wider so the shifted-out bit lands in bit 32 (left)
  // or bit 0 (right); with shamt==0 that extra bit is 0, giving carry=0 for free.
  always_comb begin
    shamt   = a[4:0];
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    sll_ext = {1'b0, b} << shamt;
    srl_ext = {b, 1'b0} >> shamt;
    sra_ext = $signed({b, 1'b0}) >>> shamt;
    slt     = $signed(a) < $signed(b);
    sltu    = a < b;
  end

  always_comb begin
    r_next        = '0;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    flag_next     = 1'b0;
    case (aluc)
      OP_ADD: begin
        r_next        = sum[31:0];
        overflow_next = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_ADDU: begin
        r_next     = sum[31:0];
        carry_next = sum[32];
      end
      OP_SUB: begin
        r_next        = diff[31:0];
        overflow_next = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      OP_SUBU: begin
        r_next     = diff[31:0];
        carry_next = diff[32];
      end
      OP_AND: r_next = a & b;
      OP_OR:  r_next = a | b;
      OP_XOR: r_next = a ^ b;
      OP_NOR: r_next = ~(a | b);
      OP_SLT: begin
        r_next    = {31'b0, slt};
        flag_next = slt;
      end
      OP_SLTU: begin
        r_next     = {31'b0, sltu};
        flag_next  = sltu;
        carry_next = sltu;
      end
      OP_SLL, OP_SLLV: begin
        r_next     = sll_ext[31:0];
        carry_next = sll_ext[32];
      end
      OP_SRL, OP_SRLV: begin
        r_next     = srl_ext[32:1];
        carry_next = srl_ext[0];
      end
      OP_SRA, OP_SRAV: begin
        r_next     = sra_ext[32:1];
        carry_next = sra_ext[0];
      end
      OP_LUI: r_next = {b[15:0], 16'h0000};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg        <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      flag_reg     <= 1'b0;
    end else begin
      r_reg        <= r_next;
      carry_reg    <= carry_next;
      overflow_reg <= overflow_next;
      flag_reg     <= flag_next;
    end
  end

  assign r        = r_reg;
  assign zero     = (r_reg == 32'd0);
  assign negative = r_reg[31];
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
  assign flag     = flag_reg;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: stimulus pushes model predictions, a monitor
// pops one prediction per clock and compares against the registered outputs.
module tb_mips_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [5:0]  aluc;
  logic [31:0] r;
  logic        zero, carry, negative, overflow, flag;

  mips_alu dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .aluc(aluc),
    .r(r), .zero(zero), .carry(carry), .negative(negative),
    .overflow(overflow), .flag(flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        zero;
    logic        carry;
    logic        negative;
    logic        overflow;
    logic        flag;
  } resp_t;

  resp_t exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [5:0] valid_ops [17] = '{
    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
    6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000100,
    6'b000010, 6'b000110, 6'b000011, 6'b000111, 6'b001111
  };

  // Reference model: plain 64-bit arithmetic and range checks.
  function automatic resp_t model(input logic rv, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [5:0] op);
    resp_t e;
    longint sa, sb, s;
    longint unsigned ua, ub, u;
    int n;
    e  = '0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = longint'(av);
    ub = longint'(bv);
    n  = int'(av[4:0]);
    if (!rv) begin
      case (op)
        6'b100000: begin
          s = sa + sb; e.r = s[31:0];
          e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        6'b100001: begin
          u = ua + ub; e.r = u[31:0]; e.carry = (u >= 64'h1_0000_0000);
        end
        6'b100010: begin
          s = sa - sb; e.r = s[31:0];
          e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        6'b100011: begin
          e.r = av - bv; e.carry = (ua < ub);
        end
        6'b100100: e.r = av & bv;
        6'b100101: e.r = av | bv;
        6'b100110: e.r = av ^ bv;
        6'b100111: e.r = ~(av | bv);
        6'b101010: begin e.flag = (sa < sb); e.r = {31'b0, e.flag}; end
        6'b101011: begin e.flag = (ua < ub); e.carry = e.flag; e.r = {31'b0, e.flag}; end
        6'b000000, 6'b000100: begin
          e.r = bv << n; e.carry = (n != 0) && bv[32-n];
        end
        6'b000010, 6'b000110: begin
          e.r = bv >> n; e.carry = (n != 0) && bv[n-1];
        end
        6'b000011, 6'b000111: begin
          e.r = bv[31] ? ~((~bv) >> n) : (bv >> n);
          e.carry = (n != 0) && bv[n-1];
        end
        6'b001111: e.r = {bv[15:0], 16'h0000};
        default: ;
      endcase
    end
    e.zero     = (e.r == 32'd0);
    e.negative = e.r[31];
    return e;
  endfunction

  task automatic apply(input logic rv, input logic [31:0] av, input logic [31:0] bv,
                       input logic [5:0] op);
    @(negedge clk);
    rst = rv; a = av; b = bv; aluc = op;
    exp_q.push_back(model(rv, av, bv, op));
    tag_q.push_back($sformatf("rst=%0b op=%b a=%h b=%h", rv, op, av, bv));
  endtask

  // Monitor: each registered output is checked just after the edge that produced it.
  initial begin
    resp_t got, want;
    string tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        tag  = tag_q.pop_front();
        got  = '{r, zero, carry, negative, overflow, flag};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL alu %s: got r=%h z=%0b c=%0b n=%0b v=%0b f=%0b, want r=%h z=%0b c=%0b n=%0b v=%0b f=%0b",
                   tag, got.r, got.zero, got.carry, got.negative, got.overflow, got.flag,
                   want.r, want.zero, want.carry, want.negative, want.overflow, want.flag);
        end else begin
          $display("ok   alu %s -> r=%h z=%0b c=%0b n=%0b v=%0b f=%0b",
                   tag, got.r, got.zero, got.carry, got.negative, got.overflow, got.flag);
        end
      end
    end
  end

  logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0010};

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rop;
    rst = 1'b1; a = '0; b = '0; aluc = '0;

    apply(1'b1, 32'h0, 32'h0, 6'b100000);
    foreach (valid_ops[i]) apply(1'b0, 32'h1c, 32'h21, valid_ops[i]);
    apply(1'b0, 32'h7FFF_FFFF, 32'h1, 6'b100000);
    apply(1'b0, 32'hFFFF_FFFF, 32'h1, 6'b100001);
    apply(1'b0, 32'h4, 32'h8000_0010, 6'b000011);
    apply(1'b0, 32'hFFFF_FFFF, 32'h1, 6'b101010);
    apply(1'b0, 32'hFFFF_FFFF, 32'h1, 6'b101011);
    apply(1'b0, 32'h8000_0000, 32'h1, 6'b100010);
    apply(1'b0, 32'h20, 32'hFFFF_FFFF, 6'b000000);
    apply(1'b0, 32'h1f, 32'hFFFF_FFFF, 6'b000010);
    apply(1'b0, 32'h1234, 32'h5678, 6'b100001);
    apply(1'b1, 32'h1234, 32'h5678, 6'b100001);
    apply(1'b0, 32'h1234, 32'h5678, 6'b111111);

    for (int i = 0; i < 400; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom) : valid_ops[$urandom_range(0, 16)];
      apply(($urandom_range(0, 49) == 0), ra, rb, rop);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
